// File: rtl/risc_pkg.sv
// Shared fetch-stage types: instruction/opcode widths, fetch FSM state encoding and
// the default reset PC.
package risc_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          OPCODE_W         = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_LOAD = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port. A read is offered while mem_req=1 with mem_addr held
// stable; the cycle in which mem_ack=1 completes it and mem_rdata is valid only then.
interface instruction_fetch_if #(
    parameter int ADDR_W = 32
);
    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_ack;
    logic [risc_pkg::INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter: a redirect load has priority over the sequential increment; the
// increment wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction words over the memory port and strobes
// them into the instruction register. Optional ack timeout enabled by FETCH_TIMEOUT_EN.
module instruction_fetch
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                PC_STEP  = 4
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int                TIMEOUT  = 15
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                next_fetch,
    input  logic                branch_en,
    input  logic [ADDR_W-1:0]   branch_target,
    instruction_fetch_if.master mem,
    output logic                ldir,
    output logic [INSTR_W-1:0]  ir_data,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                busy,
    output logic                fetch_err,
    output fetch_state_e        state_o
);
    fetch_state_e       state_q;
    logic               mem_req_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               ldir_q;
    logic [INSTR_W-1:0] ir_data_q;
    logic [ADDR_W-1:0]  pc_out_q;
    logic               redirect_pend_q;

    logic [ADDR_W-1:0]  pc;
    logic               pc_inc;
    logic               discard;

    // A redirect seen now or earlier in this request turns the returning word into a bubble.
    assign discard = branch_en | redirect_pend_q;
    assign pc_inc  = (state_q == FS_REQ) & mem.mem_ack & ~discard;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (branch_en),
        .target_i (branch_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             fetch_err_q;
    logic             timeout_hit;

    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= FS_IDLE;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= RESET_PC;
            ldir_q          <= 1'b0;
            ir_data_q       <= '0;
            pc_out_q        <= RESET_PC;
            redirect_pend_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q      <= '0;
            fetch_err_q     <= 1'b0;
`endif
        end else begin
            ldir_q <= 1'b0;
            unique case (state_q)
                FS_IDLE: begin
                    if (next_fetch) begin
                        state_q    <= FS_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= branch_en ? branch_target : pc;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                FS_REQ: begin
                    if (mem.mem_ack) begin
                        if (discard) begin
                            // Keep mem_req high and reissue at the redirected PC.
                            mem_addr_q      <= branch_en ? branch_target : pc;
                            redirect_pend_q <= 1'b0;
                        end else begin
                            state_q    <= FS_LOAD;
                            mem_req_q  <= 1'b0;
                            ldir_q     <= 1'b1;
                            ir_data_q  <= mem.mem_rdata;
                            pc_out_q   <= mem_addr_q;
                        end
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        if (timeout_hit) begin
                            fetch_err_q     <= 1'b1;
                            mem_req_q       <= 1'b0;
                            state_q         <= FS_IDLE;
                            redirect_pend_q <= 1'b0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                            if (branch_en) redirect_pend_q <= 1'b1;
                        end
`else
                        if (branch_en) redirect_pend_q <= 1'b1;
`endif
                    end
                end
                FS_LOAD: state_q <= FS_IDLE;
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign ldir         = ldir_q;
    assign ir_data      = ir_data_q;
    assign pc_out       = pc_out_q;
    assign busy         = (state_q != FS_IDLE);
    assign state_o      = state_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err    = fetch_err_q;
`else
    assign fetch_err    = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a scoreboard queue holds {addr, word} for every
// fetch that must reach the instruction register; a second instance checks PC wrap.
module tb_instruction_fetch;
    import risc_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    always #5 clk = ~clk;

    logic         next_fetch = 1'b0;
    logic         branch_en = 1'b0;
    logic [31:0]  branch_target = '0;
    logic         ldir;
    logic [31:0]  ir_data;
    logic [31:0]  pc_out;
    logic         busy;
    logic         fetch_err;
    fetch_state_e state;

    logic         w_next_fetch = 1'b0;
    logic         w_ldir;
    logic [31:0]  w_ir_data;
    logic [31:0]  w_pc_out;
    logic         w_busy;
    logic         w_fetch_err;
    fetch_state_e w_state;

    instruction_fetch_if #(.ADDR_W(32)) mem_if ();
    instruction_fetch_if #(.ADDR_W(32)) w_if ();

    instruction_fetch #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .next_fetch    (next_fetch),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem           (mem_if),
        .ldir          (ldir),
        .ir_data       (ir_data),
        .pc_out        (pc_out),
        .busy          (busy),
        .fetch_err     (fetch_err),
        .state_o       (state)
    );

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .next_fetch    (w_next_fetch),
        .branch_en     (1'b0),
        .branch_target (32'h0),
        .mem           (w_if),
        .ldir          (w_ldir),
        .ir_data       (w_ir_data),
        .pc_out        (w_pc_out),
        .busy          (w_busy),
        .fetch_err     (w_fetch_err),
        .state_o       (w_state)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fetch();
        next_fetch = 1'b1;
        tick();
        next_fetch = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_if.mem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(mem_if.mem_req), 32'd1);
    endtask

    // Holds off the ack for wait_cyc cycles, then returns data for one cycle.
    task automatic serve(input int wait_cyc, input logic [31:0] data, input bit expect_load);
        logic [31:0] addr;
        wait_req();
        addr = mem_if.mem_addr;
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check("hold_req", 32'(mem_if.mem_req), 32'd1);
            check("hold_addr", mem_if.mem_addr, addr);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = data;
        if (expect_load) exp_q.push_back({addr, data});
        tick();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = $urandom;
    endtask

    always @(negedge clk) begin : sb_monitor
        logic [63:0] e;
        if (rst && ldir) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_ir_data", ir_data, e[31:0]);
                check("sb_pc_out", pc_out, e[63:32]);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        w_if.mem_ack     = 1'b0;
        w_if.mem_rdata   = '0;
        rst = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(state), 32'(FS_IDLE));
        check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'h0);
        check("rst_ldir", 32'(ldir), 32'd0);
        check("rst_ir_data", ir_data, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
        rst = 1'b1;
        tick();

        // PC wrap on the second instance
        w_next_fetch = 1'b1;
        tick();
        w_next_fetch = 1'b0;
        check("wrap_req", 32'(w_if.mem_req), 32'd1);
        check("wrap_first_addr", w_if.mem_addr, 32'hFFFF_FFFC);
        w_if.mem_ack   = 1'b1;
        w_if.mem_rdata = 32'h0BAD_F00D;
        tick();
        w_if.mem_ack = 1'b0;
        check("wrap_ldir", 32'(w_ldir), 32'd1);
        check("wrap_ir_data", w_ir_data, 32'h0BAD_F00D);
        check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
        tick();
        w_next_fetch = 1'b1;
        tick();
        w_next_fetch = 1'b0;
        check("wrap_next_addr", w_if.mem_addr, 32'h0);
        w_if.mem_ack = 1'b1;
        tick();
        w_if.mem_ack = 1'b0;
        tick();

        // Zero-wait fetch
        pulse_fetch();
        check("req_latency", 32'(mem_if.mem_req), 32'd1);
        serve(0, 32'hAABB_CCDD, 1'b1);
        check("ldir_zero_wait", 32'(ldir), 32'd1);
        tick();
        check("ldir_single", 32'(ldir), 32'd0);
        check("ir_hold", ir_data, 32'hAABB_CCDD);
        check("pc_out_first", pc_out, 32'h0);
        check("idle_after_load", 32'(busy), 32'd0);

        // Wait states, plus a next_fetch that must be ignored while busy
        pulse_fetch();
        check("next_addr", mem_if.mem_addr, 32'h4);
        pulse_fetch();
        serve(3, 32'h1357_9BDF, 1'b1);
        check("ldir_wait_states", 32'(ldir), 32'd1);
        tick();
        check("ldir_ws_single", 32'(ldir), 32'd0);
        check("busy_fetch_ignored", 32'(busy), 32'd0);

        // Branch during REQ: returned word is dropped, request reissued at target
        pulse_fetch();
        check("addr_before_branch", mem_if.mem_addr, 32'h8);
        branch_en     = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_en = 1'b0;
        check("addr_held_on_branch", mem_if.mem_addr, 32'h8);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h1234_5678;
        tick();
        mem_if.mem_ack = 1'b0;
        check("branch_no_ldir", 32'(ldir), 32'd0);
        check("branch_req_kept", 32'(mem_if.mem_req), 32'd1);
        check("branch_new_addr", mem_if.mem_addr, 32'h40);
        serve(1, 32'hCAFE_F00D, 1'b1);
        check("branch_ldir", 32'(ldir), 32'd1);
        tick();

        // Branch and ack in the same cycle: redirect wins
        pulse_fetch();
        check("addr_after_branch", mem_if.mem_addr, 32'h44);
        branch_en        = 1'b1;
        branch_target    = 32'h100;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        tick();
        branch_en      = 1'b0;
        mem_if.mem_ack = 1'b0;
        check("same_cycle_no_ldir", 32'(ldir), 32'd0);
        check("same_cycle_addr", mem_if.mem_addr, 32'h100);
        serve(0, $urandom, 1'b1);
        tick();

        // Branch while idle
        branch_en     = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_en = 1'b0;
        pulse_fetch();
        check("idle_branch_addr", mem_if.mem_addr, 32'h200);
        serve($urandom_range(1, 3), $urandom, 1'b1);
        tick();

`ifdef FETCH_TIMEOUT_EN
        pulse_fetch();
        repeat (14) tick();
        check("req_before_timeout", 32'(mem_if.mem_req), 32'd1);
        check("err_before_timeout", 32'(fetch_err), 32'd0);
        tick();
        check("timeout_err", 32'(fetch_err), 32'd1);
        check("timeout_req_drop", 32'(mem_if.mem_req), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        tick();
        check("timeout_sticky", 32'(fetch_err), 32'd1);
        pulse_fetch();
        check("timeout_pc_kept", mem_if.mem_addr, 32'h204);
        serve(0, $urandom, 1'b1);
        tick();
`else
        pulse_fetch();
        repeat (20) tick();
        check("no_timeout_req", 32'(mem_if.mem_req), 32'd1);
        check("no_timeout_err", 32'(fetch_err), 32'd0);
        check("no_timeout_addr", mem_if.mem_addr, 32'h204);
        serve(0, $urandom, 1'b1);
        tick();
`endif

        // Asynchronous reset in the middle of a request
        pulse_fetch();
        check("busy_in_req", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("mid_rst_mem_addr", mem_if.mem_addr, 32'h0);
        check("mid_rst_ldir", 32'(ldir), 32'd0);
        check("mid_rst_ir_data", ir_data, 32'h0);
        check("mid_rst_pc_out", pc_out, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fetch_err", 32'(fetch_err), 32'd0);
        tick();
        rst              = 1'b1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_if.mem_ack = 1'b0;
        check("late_ack_no_ldir", 32'(ldir), 32'd0);
        check("late_ack_idle", 32'(busy), 32'd0);
        pulse_fetch();
        check("post_rst_addr", mem_if.mem_addr, 32'h0);
        serve(0, 32'h0F0F_A5A5, 1'b1);
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
